flash_bpi_ctrl: RTL and testbench
=================================

// Module: flash_bpi_ctrl
// PURPOSE
//  Sequencer for the ml605 16-bit parallel (BPI) NOR flash (P30 command set). Accepts one
//  word-level request at a time (read, program, block erase, read status), generates the
//  CE/OE/WE bus cycles and command sequences, polls status, and returns one response per request.
//  Sits between the control-plane flash register worker and the flash_* pins in mkFTop.
// PARAMETERS
//  RD_WAIT   10    cycles CE/OE low before read data is sampled (>=2)
//  SETUP     2     cycles addr/data/CE valid before WE falls (>=1)
//  WE_PULSE  4     cycles WE held low (>=1)
//  POLL_MAX  2**22 max status reads before timeout
// PORTS
//  CLK          in   1   clock
//  RST_N        in   1   async active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   high only in IDLE; accept on req_valid&&req_ready
//  req_op       in   2   00 read, 01 program, 10 erase block, 11 read status
//  req_addr     in   24  word address
//  req_wdata    in   16  program data
//  rsp_valid    out  1   one-cycle response pulse, no backpressure
//  rsp_data     out  16  read data (op 00) or final status register (others)
//  rsp_err      out  1   SR[5]|SR[4]|SR[1] set, or poll timeout
//  busy         out  1   ~req_ready
//  flash_addr   out  24  address pins
//  flash_dq_o   out  16  write data; flash_dq_oe out 1 tristate enable
//  flash_dq_i   in   16  pad input
//  flash_wait   in   1   active-high WAIT; stretches read sample
//  flash_ce_n, flash_oe_n, flash_we_n  out 1 each
// BEHAVIOUR
//  Reset (async, immediate): ce_n/oe_n/we_n=1, dq_oe=0, addr=0, dq_o=0, rsp_valid=0, rsp_err=0,
//   rsp_data=0, req_ready=1 after deassert; state IDLE. Reset mid-sequence abandons it, no cleanup.
//  Write cycle W(a,d): SETUP cycles ce_n=0,we_n=1,dq_oe=1; WE_PULSE cycles we_n=0;
//   1 hold cycle we_n=1; 1 cycle ce_n=1,dq_oe=0. Total SETUP+WE_PULSE+2.
//  Read cycle R(a): ce_n=0,oe_n=0,dq_oe=0 for RD_WAIT cycles; sample flash_dq_i on last cycle,
//   extended one cycle per cycle flash_wait=1 at that point; then 1 cycle ce_n=oe_n=1.
//  dq_oe and oe_n=0 never overlap; >=1 dead cycle between write and read cycles.
//  States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, WR_REC, RD_ACT, RD_REC, POLL_CHK, RESP.
//  Sequences (addr = req_addr throughout, captured at accept):
//   read:    R(a) -> RESP. Accept at cycle 0, ce_n/oe_n low cycles 1..RD_WAIT, rsp_valid at RD_WAIT+2.
//   program: W(40h) W(wdata) poll.   erase: W(20h) W(D0h) poll.   status: W(70h) R -> exit.
//   poll: R repeated until SR[7]=1 or POLL_MAX reads (timeout -> rsp_err=1).
//   exit: if rsp_err then W(50h); always W(FFh) (read-array) -> RESP.
//  RESP: rsp_valid=1 one cycle, rsp_data/rsp_err held until next RESP; next cycle IDLE, req_ready=1.
//  req_valid while busy ignored (not queued). Poll counter saturates; width clog2(POLL_MAX)+1.
// CONFIGURATION
//  FLASH_UNLOCK_EN defined: program/erase prefixed with W(60h) W(D0h) block unlock at req_addr.
//  Undefined: no unlock; locked blocks report SR[1]=1 -> rsp_err=1.
// TESTING (flash behavioural model, default params)
//  1 read 000123h, model returns BEEFh -> ce_n/oe_n low 10 cycles, rsp_valid at cycle 12, data BEEFh, err 0.
//  2 program 000010h=1234h, model SR=80h after 50 polls -> bus sees 40h,1234h, 51 reads, FFh;
//    rsp_data=0080h, err 0; model array[10h]=1234h.
//  3 erase with model SR=A0h -> bus sees 20h,D0h, polls, 50h, FFh; rsp_err=1, rsp_data=00A0h.
//  4 model never sets SR[7], POLL_MAX=16 -> exactly 16 status reads, then 50h,FFh, rsp_err=1.
//  5 flash_wait=1 for 3 cycles at sample -> rsp_valid delayed 3 cycles, correct data.
//  6 RST_N low mid WR_PULSE -> we_n/ce_n high same cycle, dq_oe 0; then read works normally.
//    Check: dq_oe&~oe_n never true; FLASH_UNLOCK_EN build shows 60h,D0h before 40h.

Source files
------------

// File: rtl/flash_bpi_ctrl.sv
// flash_bpi_ctrl: word-level sequencer for a 16-bit BPI (P30 command set) NOR flash.
// Build option: define FLASH_UNLOCK_EN to prefix program/erase with a block-unlock pair (60h, D0h).
module flash_bpi_ctrl #(
    parameter int RD_WAIT  = 10,
    parameter int SETUP    = 2,
    parameter int WE_PULSE = 4,
    parameter int POLL_MAX = 2**22
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [23:0] flash_addr,
    output logic [15:0] flash_dq_o,
    output logic        flash_dq_oe,
    input  logic [15:0] flash_dq_i,
    input  logic        flash_wait,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n
);
    localparam int PCW = $clog2(POLL_MAX) + 1;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_PROG  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;
    localparam logic [1:0] OP_STAT  = 2'b11;

    typedef enum logic [3:0] {
        IDLE, WR_SETUP, WR_PULSE, WR_HOLD, WR_REC, RD_ACT, RD_REC, POLL_CHK, RESP
    } state_t;

    // Position within the command sequence; selects the word driven by the next write cycle.
    typedef enum logic [2:0] {
        SQ_UNLK, SQ_UNLK_CF, SQ_CMD1, SQ_CMD2, SQ_POLL, SQ_CLR, SQ_ARRAY
    } step_t;

    state_t           r_state, w_nxt_state;
    step_t            r_step, w_nxt_step;
    logic [1:0]       r_op;
    logic [23:0]      r_addr;
    logic [15:0]      r_wdata;
    logic [15:0]      r_cnt;
    logic [PCW-1:0]   r_poll;
    logic [15:0]      r_rdata;
    logic             r_err, w_nxt_err;
    logic [15:0]      r_rsp_data;
    logic             r_rsp_err;
    logic             w_sample;
    logic             w_rd_last;
    logic             w_wr_bus;
    logic [15:0]      w_cmd;

    assign w_rd_last = (r_cnt == 16'(RD_WAIT - 1));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_step  = r_step;
        w_nxt_err   = r_err;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_nxt_err = 1'b0;
                    if (req_op == OP_READ) begin
                        w_nxt_state = RD_ACT;
                        w_nxt_step  = SQ_POLL;
                    end else begin
                        w_nxt_state = WR_SETUP;
`ifdef FLASH_UNLOCK_EN
                        w_nxt_step  = (req_op == OP_STAT) ? SQ_CMD1 : SQ_UNLK;
`else
                        w_nxt_step  = SQ_CMD1;
`endif
                    end
                end
            end
            WR_SETUP: if (r_cnt == 16'(SETUP - 1))    w_nxt_state = WR_PULSE;
            WR_PULSE: if (r_cnt == 16'(WE_PULSE - 1)) w_nxt_state = WR_HOLD;
            WR_HOLD:  w_nxt_state = WR_REC;
            WR_REC: begin
                case (r_step)
                    SQ_UNLK:    begin w_nxt_step = SQ_UNLK_CF; w_nxt_state = WR_SETUP; end
                    SQ_UNLK_CF: begin w_nxt_step = SQ_CMD1;    w_nxt_state = WR_SETUP; end
                    SQ_CMD1: begin
                        if (r_op == OP_STAT) begin
                            w_nxt_step  = SQ_POLL;
                            w_nxt_state = RD_ACT;
                        end else begin
                            w_nxt_step  = SQ_CMD2;
                            w_nxt_state = WR_SETUP;
                        end
                    end
                    SQ_CMD2:    begin w_nxt_step = SQ_POLL;  w_nxt_state = RD_ACT;   end
                    SQ_CLR:     begin w_nxt_step = SQ_ARRAY; w_nxt_state = WR_SETUP; end
                    default:    w_nxt_state = RESP;
                endcase
            end
            RD_ACT: begin
                if (w_rd_last && !flash_wait) begin
                    w_sample    = 1'b1;
                    w_nxt_state = RD_REC;
                end
            end
            RD_REC: w_nxt_state = (r_op == OP_READ) ? RESP : POLL_CHK;
            POLL_CHK: begin
                if (r_op == OP_STAT || r_rdata[7]) begin
                    w_nxt_err   = r_rdata[5] | r_rdata[4] | r_rdata[1];
                    w_nxt_step  = w_nxt_err ? SQ_CLR : SQ_ARRAY;
                    w_nxt_state = WR_SETUP;
                end else if (r_poll >= PCW'(POLL_MAX)) begin
                    w_nxt_err   = 1'b1;
                    w_nxt_step  = SQ_CLR;
                    w_nxt_state = WR_SETUP;
                end else begin
                    w_nxt_state = RD_ACT;
                end
            end
            RESP:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    always_comb begin
        case (r_step)
            SQ_UNLK:    w_cmd = 16'h0060;
            SQ_UNLK_CF: w_cmd = 16'h00D0;
            SQ_CMD1:    w_cmd = (r_op == OP_PROG) ? 16'h0040 :
                                (r_op == OP_ERASE) ? 16'h0020 : 16'h0070;
            SQ_CMD2:    w_cmd = (r_op == OP_PROG) ? r_wdata : 16'h00D0;
            SQ_CLR:     w_cmd = 16'h0050;
            default:    w_cmd = 16'h00FF;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_step     <= SQ_ARRAY;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_poll     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_step  <= w_nxt_step;
            r_err   <= w_nxt_err;
            // Counter restarts on every state change and freezes while WAIT stretches the read sample.
            if (w_nxt_state != r_state)
                r_cnt <= '0;
            else if (r_state != IDLE && !(r_state == RD_ACT && w_rd_last))
                r_cnt <= r_cnt + 16'd1;
            if (r_state == IDLE && req_valid) begin
                r_op    <= req_op;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_poll  <= '0;
            end
            if (w_sample) begin
                r_rdata <= flash_dq_i;
                if (r_op != OP_READ && r_poll != '1)
                    r_poll <= r_poll + 1'b1;
            end
            if (r_state != RESP && w_nxt_state == RESP) begin
                r_rsp_data <= r_rdata;
                r_rsp_err  <= w_nxt_err;
            end
        end
    end

    assign w_wr_bus    = (r_state == WR_SETUP) || (r_state == WR_PULSE) || (r_state == WR_HOLD);
    assign flash_ce_n  = !(w_wr_bus || r_state == RD_ACT);
    assign flash_oe_n  = !(r_state == RD_ACT);
    assign flash_we_n  = !(r_state == WR_PULSE);
    assign flash_dq_oe = w_wr_bus;
    assign flash_dq_o  = w_wr_bus ? w_cmd : 16'h0000;
    assign flash_addr  = r_addr;
    assign req_ready   = (r_state == IDLE);
    assign busy        = !req_ready;
    assign rsp_valid   = (r_state == RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_flash_bpi_ctrl.sv
// Scoreboard bench for flash_bpi_ctrl with a behavioural P30 flash model; honours FLASH_UNLOCK_EN.
module tb_flash_bpi_ctrl;
    localparam int RD_WAIT  = 10;
    localparam int SETUP    = 2;
    localparam int WE_PULSE = 4;
    localparam int POLL_MAX = 64;
    localparam int TMO      = 1000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [23:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [23:0] flash_addr;
    logic [15:0] flash_dq_o;
    logic        flash_dq_oe;
    logic [15:0] flash_dq_i = '0;
    logic        flash_wait = 1'b0;
    logic        flash_ce_n, flash_oe_n, flash_we_n;

    flash_bpi_ctrl #(
        .RD_WAIT(RD_WAIT), .SETUP(SETUP), .WE_PULSE(WE_PULSE), .POLL_MAX(POLL_MAX)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
        .flash_dq_i(flash_dq_i), .flash_wait(flash_wait),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n)
    );

    always #5 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;

    // flash model state
    logic [15:0] mem [int];
    bit          erased [int];
    bit          unlocked [int];
    bit          m_status = 1'b0;
    int          m_pend = 0;
    logic [7:0]  m_sr = 8'h80;
    int          m_busy = 0;
    int          cfg_busy = 0;
    int          cfg_wait = 0;
    logic [7:0]  cfg_inj = 8'h00;

    typedef struct {
        logic [1:0]       op;
        logic [23:0]      addr;
        logic [15:0]      data;
        logic             err;
        int               reads;
        int               lat;
        int               nwr;
        logic [7:0][15:0] wr;
        bit               chk_mem;
        logic [15:0]      mem_val;
    } exp_t;
    exp_t sbq[$];

    logic        prev_we = 1'b1, prev_oe = 1'b1;
    int          oe_cnt = 0, ncyc = 0, acc_cyc = 0, rdcnt = 0, overlap = 0;
    logic [23:0] wl_a[$];
    logic [15:0] wl_d[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic int blk(logic [23:0] a);
        return int'({24'h0, a[23:16]});
    endfunction

    function automatic logic [15:0] rd_mem(logic [23:0] a);
        if (mem.exists(int'({8'h0, a}))) return mem[int'({8'h0, a})];
        if (erased.exists(blk(a))) return 16'hFFFF;
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic bit is_locked(logic [23:0] a);
        return (a[23:20] == 4'hF) && !unlocked.exists(blk(a));
    endfunction

    function automatic void erase_blk(logic [23:0] a);
        int keys[$];
        foreach (mem[k]) if (((k >> 16) & 255) == blk(a)) keys.push_back(k);
        foreach (keys[i]) mem.delete(keys[i]);
        erased[blk(a)] = 1'b1;
    endfunction

    function automatic void model_write(logic [23:0] a, logic [15:0] d);
        case (m_pend)
            1: begin
                if (is_locked(a)) m_sr = 8'h82;
                else begin mem[int'({8'h0, a})] = d; m_sr = 8'h80 | cfg_inj; end
                m_busy = cfg_busy; m_status = 1'b1; m_pend = 0;
            end
            2: begin
                if (d == 16'h00D0) begin
                    if (is_locked(a)) m_sr = 8'h82;
                    else begin erase_blk(a); m_sr = 8'h80 | cfg_inj; end
                    m_busy = cfg_busy;
                end else m_sr = 8'hB0;
                m_status = 1'b1; m_pend = 0;
            end
            3: begin
                if (d == 16'h00D0) unlocked[blk(a)] = 1'b1;
                m_status = 1'b1; m_pend = 0;
            end
            default: begin
                case (d)
                    16'h0040: m_pend = 1;
                    16'h0020: m_pend = 2;
                    16'h0060: m_pend = 3;
                    16'h0070: m_status = 1'b1;
                    16'h0050: m_sr = m_sr & 8'hC5;
                    16'h00FF: m_status = 1'b0;
                    default: ;
                endcase
            end
        endcase
    endfunction

    function automatic void check_rsp();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("rsp_data op%0d @%06h", e.op, e.addr), {16'h0, rsp_data}, {16'h0, e.data});
            chk($sformatf("rsp_err op%0d @%06h", e.op, e.addr), {31'h0, rsp_err}, {31'h0, e.err});
            chk($sformatf("read_cycles op%0d @%06h", e.op, e.addr), rdcnt, e.reads);
            chk($sformatf("write_cycles op%0d @%06h", e.op, e.addr), wl_d.size(), e.nwr);
            for (int i = 0; i < e.nwr && i < wl_d.size(); i++) begin
                chk($sformatf("wr_data[%0d] op%0d", i, e.op), {16'h0, wl_d[i]}, {16'h0, e.wr[i]});
                chk($sformatf("wr_addr[%0d] op%0d", i, e.op), {8'h0, wl_a[i]}, {8'h0, e.addr});
            end
            if (e.op == 2'b00) chk("read_latency", ncyc - acc_cyc, e.lat);
            if (e.chk_mem) chk("array_after_program", {16'h0, rd_mem(e.addr)}, {16'h0, e.mem_val});
        end
        wl_a.delete();
        wl_d.delete();
        rdcnt = 0;
    endfunction

    always @(negedge CLK) begin
        ncyc++;
        if (!RST_N) begin
            prev_we = 1'b1; prev_oe = 1'b1; oe_cnt = 0; flash_wait = 1'b0;
        end else begin
            if (flash_dq_oe && !flash_oe_n) overlap++;
            if (req_valid && req_ready) acc_cyc = ncyc;
            if (!prev_we && flash_we_n) begin
                wl_a.push_back(flash_addr);
                wl_d.push_back(flash_dq_o);
                model_write(flash_addr, flash_dq_o);
            end
            if (!prev_oe && flash_oe_n) begin
                rdcnt++;
                if (m_status && m_busy > 0) m_busy--;
            end
            prev_we = flash_we_n;
            prev_oe = flash_oe_n;
            if (!flash_oe_n) oe_cnt++; else oe_cnt = 0;
            flash_wait = !flash_oe_n && oe_cnt >= RD_WAIT && oe_cnt < RD_WAIT + cfg_wait;
            flash_dq_i = m_status ? ((m_busy > 0) ? 16'h0000 : {8'h00, m_sr}) : rd_mem(flash_addr);
            if (rsp_valid) check_rsp();
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (!(req_ready && sbq.size() == 0) && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [15:0] d,
                         input int busy_n, input logic [7:0] inj, input int w, input logic [7:0] sr);
        exp_t e;
        bit locked;
        logic [7:0] fsr;
        wait_idle();
        cfg_busy = busy_n; cfg_inj = inj; cfg_wait = w;
        e.op = op; e.addr = a; e.nwr = 0; e.wr = '0; e.chk_mem = 1'b0; e.mem_val = d; e.lat = 0;
        case (op)
            2'b00: begin
                e.data = rd_mem(a); e.err = 1'b0; e.reads = 1; e.lat = RD_WAIT + 2 + w;
            end
            2'b11: begin
                m_sr = sr; m_busy = 0;
                e.data = {8'h00, sr}; e.err = |(sr & 8'h32); e.reads = 1;
                e.wr[e.nwr] = 16'h0070; e.nwr++;
            end
            default: begin
`ifdef FLASH_UNLOCK_EN
                locked = 1'b0;
                e.wr[e.nwr] = 16'h0060; e.nwr++;
                e.wr[e.nwr] = 16'h00D0; e.nwr++;
`else
                locked = is_locked(a);
`endif
                fsr = locked ? 8'h82 : (8'h80 | inj);
                if (busy_n + 1 > POLL_MAX) begin
                    e.data = 16'h0000; e.err = 1'b1; e.reads = POLL_MAX;
                end else begin
                    e.data = {8'h00, fsr}; e.err = |(fsr & 8'h32); e.reads = busy_n + 1;
                end
                e.wr[e.nwr] = (op == 2'b01) ? 16'h0040 : 16'h0020; e.nwr++;
                e.wr[e.nwr] = (op == 2'b01) ? d : 16'h00D0;         e.nwr++;
                e.chk_mem = (op == 2'b01) && !locked && (busy_n + 1 <= POLL_MAX);
            end
        endcase
        if (op != 2'b00) begin
            if (e.err) begin e.wr[e.nwr] = 16'h0050; e.nwr++; end
            e.wr[e.nwr] = 16'h00FF; e.nwr++;
        end
        @(posedge CLK); #1;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
        sbq.push_back(e);
        @(posedge CLK); #1;
        // stray request fields while busy must be ignored
        req_op = 2'($urandom); req_addr = 24'($urandom); req_wdata = 16'($urandom);
        repeat (3) @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        #900000;
        nerr++;
        $display("FAIL watchdog: run did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] op;
        logic [23:0] a;
        logic [7:0] injs [5];
        injs[0] = 8'h00; injs[1] = 8'h10; injs[2] = 8'h20; injs[3] = 8'h08; injs[4] = 8'h00;

        repeat (3) @(negedge CLK);
        chk("reset_ce_oe_we_n", {29'h0, flash_ce_n, flash_oe_n, flash_we_n}, 32'h7);
        chk("reset_dq_oe_rsp", {30'h0, flash_dq_oe, rsp_valid}, 32'h0);
        chk("reset_addr_dq", {flash_addr, 8'h0} | {16'h0, flash_dq_o}, 32'h0);
        chk("reset_rsp_data_err", {15'h0, rsp_err, rsp_data}, 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("ready_after_reset", {30'h0, req_ready, busy}, 32'h2);

        mem[int'(24'h000123)] = 16'hBEEF;
        issue(2'b00, 24'h000123, 16'h0, 0, 8'h00, 0, 8'h00);
        issue(2'b01, 24'h000010, 16'h1234, 50, 8'h00, 0, 8'h00);
        issue(2'b00, 24'h000010, 16'h0, 0, 8'h00, 0, 8'h00);
        issue(2'b10, 24'h010000, 16'h0, 5, 8'h20, 0, 8'h00);
        issue(2'b10, 24'h020000, 16'h0, TMO, 8'h00, 0, 8'h00);
        issue(2'b01, 24'h000300, 16'hCAFE, POLL_MAX - 1, 8'h00, 0, 8'h00);
        issue(2'b00, 24'h000123, 16'h0, 0, 8'h00, 3, 8'h00);
        issue(2'b11, 24'h000000, 16'h0, 0, 8'h00, 0, 8'h80);
        issue(2'b11, 24'h000000, 16'h0, 0, 8'h00, 0, 8'h92);
        issue(2'b01, 24'hF00005, 16'h7777, 2, 8'h00, 0, 8'h00);

        // abort a program mid write pulse
        wait_idle();
        cfg_busy = 0; cfg_inj = 8'h00; cfg_wait = 0;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_op = 2'b01; req_addr = 24'h000200; req_wdata = 16'h5555;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        n = 0;
        while (flash_we_n && n < 200) begin @(negedge CLK); n++; end
        chk("reach_we_pulse", {31'h0, flash_we_n}, 32'h0);
        #2 RST_N = 1'b0;
        #1;
        chk("abort_we_ce_high", {30'h0, flash_we_n, flash_ce_n}, 32'h3);
        chk("abort_dq_oe_low", {31'h0, flash_dq_oe}, 32'h0);
        chk("abort_ready_rsp", {30'h0, req_ready, rsp_valid}, 32'h2);
        chk("abort_rsp_data", {16'h0, rsp_data}, 32'h0);
        repeat (2) @(negedge CLK);
        m_status = 1'b0; m_pend = 0; m_busy = 0; m_sr = 8'h80;
        wl_a.delete(); wl_d.delete(); rdcnt = 0;
        RST_N = 1'b1;
        issue(2'b00, 24'h000123, 16'h0, 0, 8'h00, 0, 8'h00);

        for (int i = 0; i < 25; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? {4'hF, 20'($urandom)} : {4'h0, 20'($urandom)};
            if (op == 2'b00 && $urandom_range(0, 1) == 1) a = 24'h000010;
            issue(op, a, 16'($urandom),
                  ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 5),
                  injs[$urandom_range(0, 4)],
                  (op == 2'b00) ? $urandom_range(0, 3) : 0,
                  8'($urandom));
        end

        wait_idle();
        chk("queue_drained", sbq.size(), 32'd0);
        chk("dq_oe_with_oe_n_low", overlap, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
